extmem_master: RTL and testbench

- Bus initiator for the external word memory port (adr/data/byteen/rwb/en/done), the initiator end of that interface.
- Accepts single byte, halfword or word load/store requests from the processor/cache side.
- Converts the byte address to a word address plus big-endian byte enables, replicates store data onto the correct lanes, and runs one bus transaction per request.
- Waits for done, then extracts and sign- or zero-extends load data.

---
 rtl/extmem_master.sv | 142 ++++++++++++++
 tb/tb_extmem_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/extmem_master.sv
// rtl/extmem_master.sv - bus initiator for the external word memory port
// Byte/half/word load-store to big-endian word bus, with timeout and misalignment error.
module extmem_master #(
  parameter int ADR_W   = 13,
  parameter int TIMEOUT = 255
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [31:0]      wdata,
  output logic             ack,
  output logic             err,
  output logic [31:0]      rdata,
  output logic             busy,
  output logic [ADR_W-1:0] memadr,
  inout  wire  [31:0]      memdata,
  output logic [3:0]       byteen,
  output logic             rwb,
  output logic             en,
  input  logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t           r_state, w_next;
  logic             r_we, r_sgn, r_err;
  logic [ADR_W+1:0] r_addr;
  logic [1:0]       r_size;
  logic [31:0]      r_wdata, r_rdata;
  logic [7:0]       r_cnt;

  logic        w_illegal, w_timeout;
  logic [7:0]  w_cnt_next;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_lane, w_shifted, w_load;
  logic        w_unused;

  assign w_unused   = ^addr[31:ADR_W+2];
  assign w_illegal  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);
  assign w_cnt_next = r_cnt + 8'd1;
  assign w_timeout  = (w_cnt_next == 8'(TIMEOUT));
  assign w_off      = r_addr[1:0];

  always_comb begin
    w_be   = 4'b1111;
    w_lane = r_wdata;
    case (r_size)
      2'b00: begin
        w_be   = 4'b1000 >> w_off;
        w_lane = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = w_off[1] ? 4'b0011 : 4'b1100;
        w_lane = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane up to the top so byte/half extraction is offset-independent.
  assign w_shifted = memdata << {w_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_size)
      2'b00:   w_load = {{24{r_sgn & w_shifted[31]}}, w_shifted[31:24]};
      2'b01:   w_load = {{16{r_sgn & w_shifted[31]}}, w_shifted[31:16]};
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    ack    = 1'b0;
    err    = 1'b0;
    en     = 1'b0;
    busy   = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (req) w_next = w_illegal ? S_RESP : S_ACCESS;
      S_ACCESS: begin
        en = 1'b1;
        if (done || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        ack    = 1'b1;
        err    = r_err;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
    rwb    = ~(en & r_we);
    byteen = en ? w_be : 4'b0000;
  end

  assign memadr  = r_addr[ADR_W+1:2];
  assign rdata   = r_rdata;
  assign memdata = (en && !rwb) ? w_lane : 32'bz;

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_sgn   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req) begin
          r_we    <= we;
          r_sgn   <= sgn;
          r_addr  <= addr[ADR_W+1:0];
          r_size  <= size;
          r_wdata <= wdata;
          r_err   <= w_illegal;
          r_cnt   <= 8'd0;
        end
        S_ACCESS: begin
          if (done) begin
            r_err <= 1'b0;
            if (!r_we) r_rdata <= w_load;
          end else begin
            r_cnt <= w_cnt_next;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_master.sv
// tb/tb_extmem_master.sv - self-checking bench for extmem_master
// Word-addressed memory device plus an arithmetic model of expected bus and load results.
module tb_extmem_master;
  localparam int AW = 13;
  localparam int TO = 255;

  logic        ph1 = 1'b0;
  logic        reset, req, we, sgn, done;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        ack, err, busy, rwb, en;
  logic [31:0] rdata;
  logic [AW-1:0] memadr;
  logic [3:0]  byteen;
  wire  [31:0] memdata;

  extmem_master #(.ADR_W(AW), .TIMEOUT(TO)) dut (
    .ph1(ph1), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
    .sgn(sgn), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .memadr(memadr), .memdata(memdata), .byteen(byteen), .rwb(rwb), .en(en),
    .done(done)
  );

  always #5 ph1 = ~ph1;

  logic [31:0] mem  [0:255];
  logic [31:0] mmem [0:255];

  assign memdata = (en && rwb) ? mem[memadr[7:0]] : 32'bz;

  always @(posedge ph1) begin
    if (en && !rwb) begin
      for (int i = 0; i < 4; i++)
        if (byteen[i]) mem[memadr[7:0]][8*i +: 8] <= memdata[8*i +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic        e_legal, e_rwb, in_flight;
  logic [AW-1:0] e_adr;
  logic [3:0]  e_be;
  logic [31:0] e_lane, m_rdata;
  logic [31:0] seen_data;
  logic [AW-1:0] seen_adr;
  logic [3:0]  seen_be;

  always @(negedge ph1) begin
    if (!reset) begin
      if (!en) chk("rwb_when_idle", {31'b0, rwb}, 32'd1);
      if (in_flight) begin
        chk("busy_in_flight", {31'b0, busy}, 32'd1);
        if (!e_legal) chk("no_en_illegal", {31'b0, en}, 32'd0);
      end else begin
        chk("no_ack_idle", {31'b0, ack}, 32'd0);
      end
      if (en) begin
        seen_adr  = memadr;
        seen_be   = byteen;
        seen_data = memdata;
        chk("memadr", 32'(memadr), 32'(e_adr));
        chk("byteen", {28'b0, byteen}, {28'b0, e_be});
        chk("rwb", {31'b0, rwb}, {31'b0, e_rwb});
        if (!rwb) chk("memdata", memdata, e_lane);
      end
    end
  end

  // Model: legality, lanes and load results computed from byte-level arithmetic.
  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic sg, input logic [31:0] d, input int exp_n,
                       output logic [31:0] got_rd);
    logic [31:0] word, res, nw;
    logic [7:0]  bt;
    logic [15:0] hw;
    int off, n;
    logic got, exp_err;
    off     = int'(a[1:0]);
    e_legal = (s == 2'd0) || (s == 2'd1 && off % 2 == 0) || (s == 2'd2 && off == 0);
    e_adr   = AW'(a >> 2);
    e_rwb   = ~w;
    word    = mmem[a[9:2]];
    res     = m_rdata;
    case (s)
      2'd0: begin
        e_be   = 4'(1 << (3 - off));
        e_lane = {24'b0, d[7:0]} * 32'h0101_0101;
        bt     = 8'((word >> (8 * (3 - off))) & 32'hFF);
        res    = (sg && bt >= 8'h80) ? 32'hFFFF_FF00 + 32'(bt) : 32'(bt);
      end
      2'd1: begin
        e_be   = (off == 0) ? 4'hC : 4'h3;
        e_lane = {16'b0, d[15:0]} * 32'h0001_0001;
        hw     = (off == 0) ? word[31:16] : word[15:0];
        res    = (sg && hw >= 16'h8000) ? 32'hFFFF_0000 + 32'(hw) : 32'(hw);
      end
      default: begin
        e_be   = 4'hF;
        e_lane = d;
        res    = word;
      end
    endcase
    exp_err = !e_legal || (exp_n > 2);
    if (exp_err || w) res = m_rdata;

    @(negedge ph1);
    req = 1'b1; we = w; addr = a; size = s; sgn = sg; wdata = d;
    @(posedge ph1);
    #1;
    req = 1'b0;
    in_flight = 1'b1;
    n = 0;
    got = 1'b0;
    got_rd = 32'hx;
    while (n < exp_n + 5 && !got) begin
      @(negedge ph1);
      n++;
      if (ack) begin
        got = 1'b1;
        got_rd = rdata;
        chk("ack_err", {31'b0, err}, {31'b0, exp_err});
        chk("ack_rdata", rdata, res);
      end
    end
    chk("ack_latency", 32'(n), 32'(exp_n));
    @(posedge ph1);
    #1;
    in_flight = 1'b0;
    @(negedge ph1);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_ack", {31'b0, ack}, 32'd0);
    m_rdata = res;
    if (w && e_legal && !exp_err) begin
      nw = word;
      for (int i = 0; i < 4; i++) if (e_be[i]) nw[8*i +: 8] = e_lane[8*i +: 8];
      mmem[a[9:2]] = nw;
    end
  endtask

  logic [31:0] r;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; mmem[i] = 32'h0; end
    mem[8]  = 32'h1122_3344; mmem[8]  = 32'h1122_3344;
    mem[12] = 32'hA5A5_0000; mmem[12] = 32'hA5A5_0000;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 0; size = 0; sgn = 0; wdata = 0;
    done = 1'b1; in_flight = 1'b0; m_rdata = 0;
    e_legal = 1; e_rwb = 1; e_adr = 0; e_be = 0; e_lane = 0;
    repeat (3) @(negedge ph1);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_en", {31'b0, en}, 0);
    chk("rst_rwb", {31'b0, rwb}, 1);
    chk("rst_byteen", {28'b0, byteen}, 0);
    chk("rst_memadr", 32'(memadr), 0);
    reset = 1'b0;

    issue(1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF, 2, r);
    chk("lit_wst_adr", 32'(seen_adr), 32'd4);
    chk("lit_wst_be", {28'b0, seen_be}, 32'hF);
    chk("lit_wst_data", seen_data, 32'hDEAD_BEEF);
    issue(0, 32'h10, 2'd2, 0, 0, 2, r);
    chk("lit_wld", r, 32'hDEAD_BEEF);

    issue(1, 32'h21, 2'd0, 0, 32'hABCD_EF80, 2, r);
    chk("lit_bst_be", {28'b0, seen_be}, 32'h4);
    chk("lit_bst_data", seen_data, 32'h8080_8080);
    issue(0, 32'h20, 2'd2, 0, 0, 2, r);
    chk("lit_wld20", r, 32'h1180_3344);
    issue(0, 32'h21, 2'd0, 1, 0, 2, r);
    chk("lit_bld_s", r, 32'hFFFF_FF80);
    issue(0, 32'h21, 2'd0, 0, 0, 2, r);
    chk("lit_bld_u", r, 32'h0000_0080);
    issue(0, 32'h23, 2'd0, 1, 0, 2, r);
    chk("lit_bld3", r, 32'h0000_0044);

    issue(1, 32'h32, 2'd1, 0, 32'h5555_1234, 2, r);
    chk("lit_hst_be", {28'b0, seen_be}, 32'h3);
    chk("lit_hst_data", seen_data, 32'h1234_1234);
    issue(0, 32'h32, 2'd1, 1, 0, 2, r);
    chk("lit_hld2", r, 32'h0000_1234);
    issue(0, 32'h30, 2'd1, 1, 0, 2, r);
    chk("lit_hld0", r, 32'hFFFF_A5A5);
    issue(0, 32'h20, 2'd0, 0, 0, 2, r);
    chk("lit_bld0", r, 32'h0000_0011);

    issue(0, 32'h3, 2'd2, 0, 0, 1, r);
    chk("lit_misal_keep", r, 32'h0000_0011);
    issue(0, 32'h10, 2'd3, 0, 0, 1, r);
    issue(1, 32'h31, 2'd1, 0, 32'hFFFF_FFFF, 1, r);
    issue(0, 32'h30, 2'd2, 0, 0, 2, r);
    chk("lit_no_write_illegal", r, 32'hA5A5_1234);

    done = 1'b0;
    issue(0, 32'h10, 2'd2, 0, 0, TO + 1, r);
    chk("lit_timeout_keep", r, 32'hA5A5_1234);

    e_legal = 1; e_adr = AW'(4); e_be = 4'hF; e_rwb = 1;
    @(negedge ph1);
    req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'd2; sgn = 0;
    @(posedge ph1);
    #1;
    req = 1'b0;
    in_flight = 1'b1;
    repeat (3) @(negedge ph1);
    #1;
    reset = 1'b1;
    in_flight = 1'b0;
    @(posedge ph1);
    #1;
    chk("abort_en", {31'b0, en}, 0);
    chk("abort_rwb", {31'b0, rwb}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ack", {31'b0, ack}, 0);
    chk("abort_rdata", rdata, 0);
    @(negedge ph1);
    reset = 1'b0;
    done = 1'b1;
    m_rdata = 0;
    issue(0, 32'h10, 2'd2, 0, 0, 2, r);
    chk("lit_after_reset", r, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
